alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the processor's combinational ALU.
- Accepts one operation per handshake and registers result plus flags (zero, carry, negative, overflow).
- Adds XOR, shifts and an iterative multi-cycle multiply.
- Sits between the register-file read ports and the write-back/flags register; the control unit drives the handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CW, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- inValid  input  1  operands/control presented
- inReady  output  1  block can accept an operation this cycle
- inputA  input  WIDTH  operand A
- inputB  input  WIDTH  operand B / shift amount
- control  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
- outValid  output  1  one-cycle pulse: result/flags updated this cycle
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  carry/borrow/shift-out/multiply-overflow
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (sync, highest priority):
  - State goes to IDLE.
  - result=0, zero=0, carry=0, negative=0, overflow=0, outValid=0, inReady=1.
  - Multiplier accumulator and counter are cleared.
  - Reset asserted mid-MUL aborts the operation; no outValid is produced.
- Accept: an operation is accepted on an edge where inValid && inReady. inReady = (state==IDLE); it is combinational from state only, never from inValid.
- States:
  - IDLE: on accept of opcode 000–110, compute and register result/flags at that same edge; outValid=1 for the following cycle; stay in IDLE. Latency is 1, throughput is 1 op/cycle, so back-to-back accepts are legal.
  - IDLE: on accept of MUL, latch A and B, clear the accumulator, set counter=0, go to MUL. outValid=0.
  - MUL: one shift-add step per edge. Increment the counter. After WIDTH steps, register result/flags, pulse outValid, and return to IDLE.
  - MUL timing: accept at edge k gives outValid high in the cycle after edge k+WIDTH. inReady is low from edge k until that edge; inValid is ignored while in MUL.
- Arithmetic (all unsigned WIDTH-bit; result truncated to WIDTH):
  - ADD: carry = bit WIDTH of A+B. overflow = A and B have the same sign and the result sign differs.
  - SUB: result = A−B. carry = borrow (1 iff A<B unsigned). overflow = A and B have different signs and the result sign differs from A.
  - AND/OR/XOR: carry=0, overflow=0.
  - SHL/SHR: shift amount = full inputB value.
    - amount 0: result=A, carry=0.
    - 1 ≤ amount < WIDTH: carry = last bit shifted out.
    - amount ≥ WIDTH: result=0, carry=0.
    - overflow=0.
  - MUL: result = low WIDTH bits of A*B. carry=1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero. overflow=0.
- Flags: zero and negative are derived from the new result. All flags update only on the outValid edge and hold between operations.
- outValid is a single-cycle pulse. result and flags hold until the next completion or reset.

Test Plan:
- Reset, then ADD A=0xFF, B=0x01 → next cycle outValid=1, result=0x00, zero=1, carry=1, overflow=0. One cycle later outValid=0 and the values hold.
- SUB A=0x80, B=0x01 → result=0x7F, overflow=1, carry=0, negative=0. Then SUB A=0x01, B=0x02 → result=0xFF, carry=1, negative=1.
- MUL A=15, B=17, WIDTH=8 → inReady=0 for 8 cycles, inValid ignored meanwhile. outValid in the cycle after edge k+8 with result=0xFF, carry=0. Then MUL 16*16 → result=0x00, carry=1, zero=1.
- Back-to-back: XOR 0xAA^0x55, then SHL 0x81 by 1, then SHR 0x81 by 9 on consecutive cycles.
  - Expected: three consecutive outValid pulses.
  - Results: 0xFF; 0x02 with carry=1; 0x00 with carry=0 and zero=1.
- Reset asserted 3 cycles into MUL → next cycle inReady=1, all outputs 0, no outValid. A following ADD 2+3 → result=0x05.
- Hold inValid=0 for 5 cycles after an op → outValid stays 0 and result/flags are unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result and flags.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR; MUL runs as an iterative shift-add over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [2:0]       control,
  output logic             outValid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 negative_q, negative_d;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       diff_ext;
  logic [2*WIDTH-1:0]   shl_wide;
  logic [2*WIDTH-1:0]   shr_wide;
  logic                 shift_in_range;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic [2*WIDTH-1:0]   mul_addend;
  logic [2*WIDTH-1:0]   mul_product;

  // State and datapath registers, synchronous reset clears everything including the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  // Single-cycle operation results; shifts take the full inputB value as the amount.
  always_comb begin
    sum_ext        = {1'b0, inputA} + {1'b0, inputB};
    diff_ext       = {1'b0, inputA} - {1'b0, inputB};
    shl_wide       = {{WIDTH{1'b0}}, inputA} << inputB;
    shr_wide       = {inputA, {WIDTH{1'b0}}} >> inputB;
    shift_in_range = ({1'b0, inputB} < WIDTH_EXT);
    alu_res        = '0;
    alu_carry      = 1'b0;
    alu_ovf        = 1'b0;
    case (control)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (inputA[WIDTH-1] != inputB[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != inputA[WIDTH-1]);
      end
      OP_AND: alu_res = inputA & inputB;
      OP_OR:  alu_res = inputA | inputB;
      OP_XOR: alu_res = inputA ^ inputB;
      OP_SHL: begin
        if (shift_in_range) begin
          alu_res   = shl_wide[WIDTH-1:0];
          alu_carry = shl_wide[WIDTH];
        end
      end
      OP_SHR: begin
        if (shift_in_range) begin
          alu_res   = shr_wide[2*WIDTH-1:WIDTH];
          alu_carry = shr_wide[WIDTH-1];
        end
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
      end
    endcase
  end

  // Next-state logic: MUL leaves IDLE, and the final shift-add step returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && control == OP_MUL) state_d = MUL;
      MUL:     if (cnt_q == LAST_STEP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath updates: flags only change on a completing edge.
  always_comb begin
    inReady     = (state_q == IDLE);
    accept      = inValid && inReady;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_addend  = mplier_q[0] ? mcand_q : '0;
    mul_product = acc_q + mul_addend;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (control == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, inputA};
            mplier_d = inputB;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            negative_d  = alu_res[WIDTH-1];
            overflow_d  = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_product;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          result_d    = mul_product[WIDTH-1:0];
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          carry_d     = |mul_product[2*WIDTH-1:WIDTH];
          negative_d  = mul_product[WIDTH-1];
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign outValid = out_valid_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic [2:0] control;
  logic       outValid;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       negative;
  logic       overflow;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } exp_t;

  exp_t expQueue[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inputA(inputA), .inputB(inputB), .control(control),
    .outValid(outValid), .result(result), .zero(zero), .carry(carry),
    .negative(negative), .overflow(overflow)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one operation for one edge and record its expected completion.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] eRes, input logic eZ, input logic eC,
                               input logic eN, input logic eV);
    exp_t e;
    e.res = eRes; e.z = eZ; e.c = eC; e.n = eN; e.v = eV;
    expQueue.push_back(e);
    control = op;
    inputA  = a;
    inputB  = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Monitor: every outValid pulse pops one expected record and compares it.
  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      if (expQueue.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_outValid: got result=0x%0h with no pending operation", result);
      end else begin
        exp_t e;
        e = expQueue.pop_front();
        total++;
        if ({result, zero, carry, negative, overflow} !== e) begin
          bad++;
          $display("[TB] FAIL completion: got res=0x%0h z=%0b c=%0b n=%0b v=%0b expected res=0x%0h z=%0b c=%0b n=%0b v=%0b",
                   result, zero, carry, negative, overflow, e.res, e.z, e.c, e.n, e.v);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    inValid = 1'b0;
    inputA  = '0;
    inputB  = '0;
    control = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_result", result, 8'h00);
    checkOutput("reset_flags", {zero, carry, negative, overflow}, 4'b0000);
    checkOutput("reset_outValid", outValid, 1'b0);
    checkOutput("reset_inReady", inReady, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD with carry-out to zero, then values hold with outValid low
    applyStimulus(3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("add_hold_outValid", outValid, 1'b0);
    checkOutput("add_hold_result", result, 8'h00);
    checkOutput("add_hold_flags", {zero, carry, negative, overflow}, 4'b1100);
    @(posedge clk);
    #1;

    // SUB cases: signed overflow, then borrow
    applyStimulus(3'b001, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1);
    applyStimulus(3'b001, 8'h01, 8'h02, 8'hFF, 0, 1, 1, 0);
    applyStimulus(3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
    applyStimulus(3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
    applyStimulus(3'b011, 8'h0F, 8'hF0, 8'hFF, 0, 0, 1, 0);

    // MUL 15*17 with inValid held high (ignored) during the multiply
    applyStimulus(3'b111, 8'd15, 8'd17, 8'hFF, 0, 0, 1, 0);
    control = 3'b000;
    inputA  = 8'h11;
    inputB  = 8'h22;
    inValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mul_busy_inReady_%0d", i), inReady, 1'b0);
      checkOutput($sformatf("mul_busy_outValid_%0d", i), outValid, 1'b0);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("mul_done_inReady", inReady, 1'b1);
    @(posedge clk);
    #1;

    // MUL 16*16 overflows into the upper half
    applyStimulus(3'b111, 8'd16, 8'd16, 8'h00, 1, 1, 0, 0);
    repeat (9) @(posedge clk);
    #1;

    // Back-to-back single-cycle ops, including shift boundaries
    applyStimulus(3'b100, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0);
    applyStimulus(3'b101, 8'h81, 8'd1, 8'h02, 0, 1, 0, 0);
    applyStimulus(3'b110, 8'h81, 8'd9, 8'h00, 1, 0, 0, 0);
    applyStimulus(3'b110, 8'h81, 8'd1, 8'h40, 0, 1, 0, 0);
    applyStimulus(3'b101, 8'h81, 8'd0, 8'h81, 0, 0, 1, 0);
    applyStimulus(3'b101, 8'h01, 8'd7, 8'h80, 0, 0, 1, 0);
    applyStimulus(3'b101, 8'h03, 8'd7, 8'h80, 0, 1, 1, 0);
    applyStimulus(3'b110, 8'h80, 8'd8, 8'h00, 1, 0, 0, 0);
    applyStimulus(3'b110, 8'h80, 8'd7, 8'h01, 0, 0, 0, 0);

    // Reset three cycles into a MUL aborts it without a completion
    @(posedge clk);
    #1;
    control = 3'b111;
    inputA  = 8'd7;
    inputB  = 8'd9;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_inReady", inReady, 1'b1);
    checkOutput("abort_outValid", outValid, 1'b0);
    checkOutput("abort_result", result, 8'h00);
    checkOutput("abort_flags", {zero, carry, negative, overflow}, 4'b0000);
    repeat (10) begin
      @(negedge clk);
      checkOutput("abort_no_outValid", outValid, 1'b0);
    end
    @(posedge clk);
    #1;

    // ADD after abort, then idle cycles keep result and flags
    applyStimulus(3'b000, 8'd2, 8'd3, 8'h05, 0, 0, 0, 0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_outValid_%0d", i), outValid, 1'b0);
      checkOutput($sformatf("idle_result_%0d", i), result, 8'h05);
      checkOutput($sformatf("idle_flags_%0d", i), {zero, carry, negative, overflow}, 4'b0000);
    end

    for (int i = 0; i < 50 && expQueue.size() > 0; i++) @(negedge clk);
    checkOutput("pending_completions", expQueue.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
